// File: rtl/cpu_types_pkg.sv
// Shared word, RAM-status and arbiter-state types for the cache-to-RAM arbiter,
// plus a counter-width helper used to size the streak and timeout counters.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  // Load value returned to the owning cache when a grant is aborted.
  localparam word_t TIMEOUT_LOAD = 32'hBAD1BAD1;

  function automatic int unsigned cnt_width(input int unsigned max_val,
                                            input int unsigned min_w);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < min_w) ? min_w : w;
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Next-grant selection: dcache wins unless the icache has waited through a full
// dcache streak, in which case the icache is forced through.
module arb_prio_sel
  import cpu_types_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned SW          = cnt_width(DSTREAK_MAX, 1)
) (
  input  logic          i_dren,
  input  logic          i_dwen,
  input  logic          i_iren,
  input  logic [SW-1:0] i_streak,
  output arb_state_t    o_next
);

  localparam logic [SW-1:0] STREAK_LIM = SW'(DSTREAK_MAX);

  logic w_dreq;
  logic w_force_i;

  assign w_dreq    = i_dren | i_dwen;
  assign w_force_i = i_iren && (i_streak == STREAK_LIM);

  // NOTE: o_next gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    o_next = IDLE;
    if (w_dreq && !w_force_i) begin
      o_next = DGNT;
    end else if (i_iren) begin
      o_next = IGNT;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache fetches and dcache loads/stores onto one RAM port.
// Define MEM_ARBITER_TIMEOUT_EN to abort grants that never see RAM ACCESS.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       iREN,
  input  word_t      iaddr,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       iwait,
  output logic       dwait,
  output word_t      iload,
  output word_t      dload,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic [1:0] ramstate,
  output logic       timeout_err
);

  localparam int unsigned   SW         = cnt_width(DSTREAK_MAX, 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(DSTREAK_MAX);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  arb_state_t    w_arb_sel;
  word_t         r_addr;
  word_t         r_store;
  logic          r_wr;
  logic [SW-1:0] r_streak;
  logic          w_grant;
  logic          w_access;
  logic          w_error;
  logic          w_timeout;
  logic          w_done;

  arb_prio_sel #(
    .DSTREAK_MAX (DSTREAK_MAX),
    .SW          (SW)
  ) u_prio_sel (
    .i_dren   (dREN),
    .i_dwen   (dWEN),
    .i_iren   (iREN),
    .i_streak (r_streak),
    .o_next   (w_arb_sel)
  );

  assign w_grant  = (r_state != IDLE);
  assign w_access = w_grant && (ramstate == ACCESS);
  assign w_error  = w_grant && (ramstate == ERROR);
  assign w_done   = w_access || w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       w_state_nxt = w_arb_sel;
      IGNT, DGNT: if (w_done || w_error) w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_store  <= '0;
      r_wr     <= 1'b0;
      r_streak <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        case (w_arb_sel)
          DGNT: begin
            r_addr   <= daddr;
            r_store  <= dWEN ? dstore : '0;
            r_wr     <= dWEN;
            r_streak <= !iREN ? '0
                      : (r_streak == STREAK_LIM) ? r_streak : r_streak + 1'b1;
          end
          IGNT: begin
            r_addr   <= iaddr;
            r_store  <= '0;
            r_wr     <= 1'b0;
            r_streak <= '0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES, 8);

  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tmo_cnt <= '0;
    end else if (!w_grant) begin
      r_tmo_cnt <= '0;
    end else if (!w_access) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = w_grant && !w_access && (r_tmo_cnt == TW'(TIMEOUT_CYCLES));
`else
  // TIMEOUT_CYCLES stays on the interface so both builds share one instantiation.
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  assign ramREN      = (r_state == IGNT) || ((r_state == DGNT) && !r_wr);
  assign ramWEN      = (r_state == DGNT) && r_wr;
  assign ramaddr     = r_addr;
  assign ramstore    = r_store;
  assign timeout_err = w_timeout;

  assign iwait = !((r_state == IGNT) && w_done);
  assign dwait = !((r_state == DGNT) && w_done);

  assign iload = ((r_state == IGNT) && w_done) ? (w_access ? ramload : TIMEOUT_LOAD) : '0;
  assign dload = ((r_state == DGNT) && w_access && !r_wr) ? ramload
               : ((r_state == DGNT) && w_timeout)         ? TIMEOUT_LOAD
               : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fetch, priority, streak guard, write
// withdrawal, ERROR retry, timeout behaviour and asynchronous reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int EXP_EVT = 65;
`else
  localparam int EXP_EVT = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(
    .DSTREAK_MAX    (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .iwait       (iwait),
    .dwait       (dwait),
    .iload       (iload),
    .dload       (dload),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ramstate    (ramstate),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_evt;
    logic [31:0] evt_load;
    logic evt_err;
    logic after_err;

    // Reset values
    repeat (2) @(posedge CLK);
    #1;
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_tmo", timeout_err, 0);
    RST = 1'b0;
    cyc();

    // Isolated icache read: strobe from cycle 1, completion in cycle 4
    cyc(); iREN = 1; iaddr = 32'h40; ramstate = FREE; #1;
    check("t1_c0_ren", ramREN, 0);
    cyc(); #1;
    check("t1_c1_ren", ramREN, 1);
    check("t1_c1_addr", ramaddr, 32'h40);
    check("t1_c1_iwait", iwait, 1);
    cyc(); ramstate = BUSY; #1;
    check("t1_c2_iwait", iwait, 1);
    check("t1_c2_iload", iload, 0);
    cyc(); #1;
    check("t1_c3_iwait", iwait, 1);
    cyc(); ramstate = ACCESS; ramload = 32'h8C010004; #1;
    check("t1_c4_iwait", iwait, 0);
    check("t1_c4_iload", iload, 32'h8C010004);
    check("t1_c4_dwait", dwait, 1);
    check("t1_c4_tmo", timeout_err, 0);
    cyc(); iREN = 0; ramstate = FREE; #1;
    check("t1_c5_ren", ramREN, 0);
    check("t1_c5_iwait", iwait, 1);
    check("t1_c5_iload", iload, 0);

    // Simultaneous requests: dcache first, icache after one IDLE cycle
    cyc(); iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; #1;
    check("t2_c0_ren", ramREN, 0);
    cyc(); ramstate = ACCESS; ramload = 32'h11112222; #1;
    check("t2_c1_addr", ramaddr, 32'h100);
    check("t2_c1_ren", ramREN, 1);
    check("t2_c1_wen", ramWEN, 0);
    check("t2_c1_dwait", dwait, 0);
    check("t2_c1_dload", dload, 32'h11112222);
    check("t2_c1_iwait", iwait, 1);
    cyc(); dREN = 0; ramstate = FREE; #1;
    check("t2_c2_ren", ramREN, 0);
    check("t2_c2_dwait", dwait, 1);
    check("t2_c2_iwait", iwait, 1);
    cyc(); ramstate = ACCESS; ramload = 32'h33334444; #1;
    check("t2_c3_addr", ramaddr, 32'h44);
    check("t2_c3_iwait", iwait, 0);
    check("t2_c3_iload", iload, 32'h33334444);
    check("t2_c3_dload", dload, 0);
    cyc(); iREN = 0; ramstate = FREE; #1;

    // Starvation guard: four dcache completions, then the icache, then dcache again
    cyc(); dREN = 1; iREN = 1; daddr = 32'h180; iaddr = 32'h48;
    ramstate = ACCESS; ramload = 32'h5555AAAA; #1;
    check("t3_c0_dwait", dwait, 1);
    for (int i = 1; i <= 11; i++) begin
      cyc(); #1;
      check($sformatf("t3_c%0d_dwait", i), dwait, (i == 1 || i == 3 || i == 5 || i == 7 || i == 11) ? 0 : 1);
      check($sformatf("t3_c%0d_iwait", i), iwait, (i == 9) ? 0 : 1);
      if (i == 1) check("t3_c1_dload", dload, 32'h5555AAAA);
      if (i == 9) check("t3_c9_addr", ramaddr, 32'h48);
    end
    cyc(); dREN = 0; iREN = 0; ramstate = FREE; #1;

    // Write with dREN+dWEN, withdrawn after one cycle
    cyc(); dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF; #1;
    cyc(); dREN = 0; dWEN = 0; daddr = 0; dstore = 0; #1;
    check("t4_c1_wen", ramWEN, 1);
    check("t4_c1_ren", ramREN, 0);
    check("t4_c1_addr", ramaddr, 32'h200);
    check("t4_c1_store", ramstore, 32'hDEADBEEF);
    check("t4_c1_dwait", dwait, 1);
    cyc(); ramstate = BUSY; #1;
    check("t4_c2_wen", ramWEN, 1);
    check("t4_c2_store", ramstore, 32'hDEADBEEF);
    cyc(); ramstate = ACCESS; ramload = 32'hFFFFFFFF; #1;
    check("t4_c3_dwait", dwait, 0);
    check("t4_c3_dload", dload, 0);
    cyc(); ramstate = FREE; #1;
    check("t4_c4_wen", ramWEN, 0);
    check("t4_c4_dwait", dwait, 1);

    // ERROR then retry on the still-asserted read
    cyc(); dREN = 1; daddr = 32'h300; #1;
    cyc(); ramstate = ERROR; #1;
    check("t5_c1_ren", ramREN, 1);
    check("t5_c1_dwait", dwait, 1);
    check("t5_c1_dload", dload, 0);
    cyc(); ramstate = FREE; #1;
    check("t5_c2_ren", ramREN, 0);
    check("t5_c2_dwait", dwait, 1);
    cyc(); ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    check("t5_c3_addr", ramaddr, 32'h300);
    check("t5_c3_dwait", dwait, 0);
    check("t5_c3_dload", dload, 32'hCAFEF00D);
    cyc(); dREN = 0; ramstate = FREE; #1;

    // RAM stuck BUSY: timeout at 64 cycles after grant entry, or wait forever
    cyc(); iREN = 1; iaddr = 32'h80; ramstate = BUSY; #1;
    first_evt = 0; evt_load = '0; evt_err = 1'b0; after_err = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      cyc(); #1;
      if (first_evt != 0 && i == first_evt + 1) after_err = timeout_err;
      if (first_evt == 0 && (timeout_err || !iwait)) begin
        first_evt = i;
        evt_load  = iload;
        evt_err   = timeout_err;
      end
      if (i == 10) check("t6_iload_wait", iload, 0);
    end
    check("t6_first_evt", first_evt, EXP_EVT);
`ifdef MEM_ARBITER_TIMEOUT_EN
    check("t6_evt_load", evt_load, 32'hBAD1BAD1);
    check("t6_evt_err", evt_err, 1);
    check("t6_pulse_len", after_err, 0);
`endif
    check("t6_c200_ren", ramREN, 1);

    // Asynchronous reset in the middle of a grant
    #2; RST = 1; #1;
    check("t7_ren", ramREN, 0);
    check("t7_iwait", iwait, 1);
    check("t7_addr", ramaddr, 0);
    check("t7_tmo", timeout_err, 0);
    iREN = 0; ramstate = FREE;
    cyc(); RST = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter directly downstream of the icache/dcache pair.
- Accepts instruction-fetch and data read/write requests from the two caches and serializes them onto one RAM port.
- Returns a one-cycle completion (wait deasserted) plus load data to the requesting cache.
- Data requests have priority over instruction requests; a streak limit prevents icache starvation.

Parameters:
- DSTREAK_MAX, 4: consecutive dcache grants allowed while iREN is pending before the icache is forced a grant.
- TIMEOUT_CYCLES, 64: cycles in a grant state without RAM ACCESS before abort (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- iwait  out  1  low for exactly the icache completion cycle.
- dwait  out  1  low for exactly the dcache completion cycle.
- iload  out  32  instruction data, valid when iwait=0.
- dload  out  32  read data, valid when dwait=0 on a read.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- timeout_err  out  1  one-cycle abort pulse (tied 0 without the optional feature).

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, iwait=1, dwait=1, iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, streak=0, timeout_err=0.
- States: IDLE, IGNT, DGNT.
- IDLE arbitration, evaluated each cycle on registered state:
  - (dREN|dWEN) and not (iREN and streak==DSTREAK_MAX) -> DGNT.
  - Else iREN -> IGNT.
  - Else stay in IDLE.
- On entry to a grant state: latch address/op/data into request registers.
  - DGNT with dWEN=1 latches a write; dWEN takes precedence if dREN and dWEN are both high.
  - RAM strobes are driven from the latched registers starting the cycle after the request is first seen, giving a minimum request-to-strobe latency of 1 cycle.
- Streak counter:
  - On a DGNT entry with iREN=1, streak increments, saturating at DSTREAK_MAX.
  - On any IGNT entry, streak clears to 0.
  - On a DGNT entry with iREN=0, streak clears to 0.
- Grant state, ramstate==ACCESS (completion cycle):
  - The owning wait goes 0 combinationally and the matching load = ramload for reads.
  - For a write, dload=0.
  - Next state=IDLE; strobes drop the next cycle.
- Grant state, ramstate==BUSY or FREE: hold strobes, address and data unchanged; wait stays 1.
- Grant state, ramstate==ERROR: drop to IDLE without a completion (wait stays 1); the cache's still-asserted request is re-arbitrated, which gives an implicit retry.
- Request withdrawn mid-grant: the transaction still runs to completion and a wait pulse is still produced.
- Outside its completion cycle, each load output is 0.
- Both waits are never low in the same cycle.
- Back-to-back transactions are separated by at least one IDLE cycle.
- Reset asserted mid-transaction: immediate return to reset values; the in-flight RAM access is abandoned.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- With the macro:
  - An 8-bit-or-wider cycle counter clears on grant entry and increments each grant cycle without ACCESS.
  - On reaching TIMEOUT_CYCLES: timeout_err=1 for one cycle, the owning wait goes 0 with load=32'hBAD1BAD1, and next state=IDLE.
- Without the macro: no counter; a grant waits indefinitely for ACCESS; timeout_err is constant 0.

Decomposition:
- cpu_types_pkg: word_t (32-bit), ramstate_t enum (FREE/BUSY/ACCESS/ERROR), arb_state_t enum (IDLE/IGNT/DGNT).
- Sub-module arb_prio_sel: pure combinational next-grant selection from dREN, dWEN, iREN, streak and DSTREAK_MAX.
- The FSM, latches and counters stay in mem_arbiter.

Test Plan:
- Isolated icache read: iREN=1, iaddr=0x40, RAM answers ACCESS after 2 BUSY cycles with 0x8C010004 -> ramREN high from cycle 1, iwait=0 and iload=0x8C010004 in cycle 4 only, ramREN=0 in cycle 5.
- Simultaneous requests: iREN=1, dREN=1, daddr=0x100 -> DGNT first, ramaddr=0x100; IGNT follows after the dcache completion plus one IDLE cycle.
- Starvation guard, DSTREAK_MAX=4: dREN held high continuously with iREN=1 -> four dcache completions, then an icache grant, streak=0.
- Write with withdrawal: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, dWEN dropped after 1 cycle -> ramWEN/ramstore held until ACCESS, dwait=0 for one cycle, dload=0.
- ERROR retry: ramstate=ERROR during DGNT with dREN held -> IDLE, dwait stays 1, re-grant, completion on a later ACCESS with correct data.
- Timeout (macro on, TIMEOUT_CYCLES=64) with ramstate stuck BUSY -> timeout_err pulse and iwait=0 with iload=0xBAD1BAD1 exactly 64 cycles after grant entry; macro off -> no pulse, still waiting at 200 cycles.
